// File: rtl/gcd_controller.sv
// Control FSM for the 16-bit subtractive GCD datapath: load A, load B, then one subtraction per cycle until A==B.
// Optional iteration timeout enabled by defining GCD_TIMEOUT_EN (adds the counter and the ERROR state).
module gcd_controller #(
  parameter int MAX_ITER = 65535,
  parameter int CNT_W    = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_gt,
  input  logic       i_lt,
  input  logic       i_eq,
  output logic       o_ld_a,
  output logic       o_ld_b,
  output logic       o_sel,
  output logic       o_sel_in,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [2:0] o_state
);

  // Handshake: i_start is a request honoured only in S_IDLE; o_done (with o_err) is a
  // single-cycle completion pulse, after which the A register holds the result.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  if (CNT_W < 1 || MAX_ITER < 1 || MAX_ITER > (2 ** CNT_W) - 1) begin : g_bad_cfg
    $error("gcd_controller: CNT_W too narrow for MAX_ITER");
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

`ifdef GCD_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_expired;

  // Counts subtractions of the current run; the bound is checked before each load.
  always_ff @(posedge i_clk) begin
    if (i_rst)          r_cnt <= '0;
    else if (w_cnt_clr) r_cnt <= '0;
    else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
  end

  assign w_expired = (r_cnt == CNT_W'(MAX_ITER));
`endif

  always_comb begin
    w_next   = r_state;
    o_ld_a   = 1'b0;
    o_ld_b   = 1'b0;
    o_sel    = 1'b0;
    o_sel_in = 1'b0;
    o_done   = 1'b0;
    o_err    = 1'b0;
    o_busy   = (r_state != S_IDLE);
`ifdef GCD_TIMEOUT_EN
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_LOAD_A;
      end
      S_LOAD_A: begin
        o_sel_in = 1'b1;
        o_ld_a   = 1'b1;
        w_next   = S_LOAD_B;
      end
      S_LOAD_B: begin
        o_sel_in = 1'b1;
        o_ld_b   = 1'b1;
        w_next   = S_COMPUTE;
`ifdef GCD_TIMEOUT_EN
        w_cnt_clr = 1'b1;
`endif
      end
      S_COMPUTE: begin
        if (i_eq) begin
          w_next = S_DONE;
`ifdef GCD_TIMEOUT_EN
        end else if (w_expired) begin
          w_next = S_ERROR;
`endif
        end else if (i_gt) begin
          o_ld_a = 1'b1;
`ifdef GCD_TIMEOUT_EN
          w_cnt_inc = 1'b1;
`endif
        end else if (i_lt) begin
          o_sel  = 1'b1;
          o_ld_b = 1'b1;
`ifdef GCD_TIMEOUT_EN
          w_cnt_inc = 1'b1;
`endif
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
`ifdef GCD_TIMEOUT_EN
      S_ERROR: begin
        o_done = 1'b1;
        o_err  = 1'b1;
        w_next = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  assign o_state = r_state;

endmodule
